// File: rtl/threading_pkg.sv
// Shared constants and types for the lane thread issuer and the SIMT lane it feeds.
package threading_pkg;

    localparam int NUM_THREADS  = 16;
    localparam int THREAD_IDX_W = 4;
    localparam int BIDX_W       = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        FLUSH = 2'd2
    } issuer_state_t;

    typedef struct packed {
        logic [3:0]  funct4;
        logic [31:0] imm;
        logic [4:0]  ad1;
        logic [4:0]  ad2;
        logic [4:0]  ad3;
        logic        is_int;
        logic        is_float;
        logic        we3;
    } lane_instr_t;

    // Integer wins a double unit select; with no unit selected nothing may be written.
    function automatic lane_instr_t sanitize_instr(input lane_instr_t raw);
        lane_instr_t s;
        s = raw;
        if (raw.is_int && raw.is_float)
            s.is_float = 1'b0;
        s.we3 = raw.we3 & (raw.is_int | raw.is_float);
        return s;
    endfunction

endpackage

// File: rtl/thread_mask_ffs.sv
// Finds the lowest set mask bit strictly above idx_i, or from bit 0 when start_i is set.
module thread_mask_ffs
    import threading_pkg::*;
(
    input  logic [NUM_THREADS-1:0]  mask_i,
    input  logic [THREAD_IDX_W-1:0] idx_i,
    input  logic                    start_i,
    output logic [THREAD_IDX_W-1:0] next_o,
    output logic                    found_o
);

    // Scanning downward lets the lowest qualifying bit overwrite the result last.
    always_comb begin
        next_o  = '0;
        found_o = 1'b0;
        for (int i = NUM_THREADS - 1; i >= 0; i--) begin
            if (mask_i[i] && (start_i || (i > int'(idx_i)))) begin
                next_o  = THREAD_IDX_W'(i);
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lane_thread_issuer.sv
// Accepts one decoded instruction and replays it once per active thread into the SIMT lane.
module lane_thread_issuer
    import threading_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [3:0]              in_funct4,
    input  logic [31:0]             in_imm,
    input  logic [4:0]              in_ad1,
    input  logic [4:0]              in_ad2,
    input  logic [4:0]              in_ad3,
    input  logic                    in_is_int,
    input  logic                    in_is_float,
    input  logic                    in_we3,
    input  logic [NUM_THREADS-1:0]  in_mask,
    input  logic [BIDX_W-1:0]       in_bidx,
    input  logic                    stall,
    output logic                    lane_valid,
    output logic [THREAD_IDX_W-1:0] threads,
    output logic [BIDX_W-1:0]       bIdx,
    output logic [3:0]              FUNCT4,
    output logic [31:0]             IMM,
    output logic [4:0]              AD1,
    output logic [4:0]              AD2,
    output logic [4:0]              AD3,
    output logic                    is_int,
    output logic                    is_float,
    output logic                    WE3,
    output logic                    busy,
    output logic                    done
);

    issuer_state_t           state_q, state_d;
    lane_instr_t             instr_q, instr_d;
    logic [NUM_THREADS-1:0]  mask_q, mask_d;
    logic [BIDX_W-1:0]       bidx_q, bidx_d;
    logic [THREAD_IDX_W-1:0] thr_q, thr_d;
    logic                    vld_q, vld_d;
    logic                    we3_q, we3_d;
    logic                    done_q, done_d;

    lane_instr_t             in_raw, in_instr;
    logic                    idle;
    logic [NUM_THREADS-1:0]  sel_mask;
    logic [THREAD_IDX_W-1:0] nxt_idx;
    logic                    nxt_found;
    logic                    more_after;

    always_comb begin
        in_raw          = '0;
        in_raw.funct4   = in_funct4;
        in_raw.imm      = in_imm;
        in_raw.ad1      = in_ad1;
        in_raw.ad2      = in_ad2;
        in_raw.ad3      = in_ad3;
        in_raw.is_int   = in_is_int;
        in_raw.is_float = in_is_float;
        in_raw.we3      = in_we3;
    end

    assign in_instr = sanitize_instr(in_raw);
    assign idle     = (state_q == IDLE);
    assign sel_mask = idle ? in_mask : mask_q;

    thread_mask_ffs u_ffs (
        .mask_i  (sel_mask),
        .idx_i   (thr_q),
        .start_i (idle),
        .next_o  (nxt_idx),
        .found_o (nxt_found)
    );

    // Whether any thread remains above the one about to be issued decides done.
    assign more_after = |((sel_mask >> nxt_idx) >> 1);

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        mask_d  = mask_q;
        bidx_d  = bidx_q;
        thr_d   = thr_q;
        vld_d   = vld_q;
        we3_d   = we3_q;
        done_d  = done_q;
        case (state_q)
            IDLE: begin
                vld_d  = 1'b0;
                we3_d  = 1'b0;
                done_d = 1'b0;
                if (in_valid) begin
                    instr_d = in_instr;
                    mask_d  = in_mask;
                    bidx_d  = in_bidx;
                    if (nxt_found) begin
                        state_d = ISSUE;
                        thr_d   = nxt_idx;
                        vld_d   = 1'b1;
                        we3_d   = in_instr.we3;
                        done_d  = !more_after;
                    end else begin
                        state_d = FLUSH;
                        done_d  = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (!stall) begin
                    if (done_q) begin
                        state_d = IDLE;
                        vld_d   = 1'b0;
                        we3_d   = 1'b0;
                        done_d  = 1'b0;
                    end else begin
                        thr_d  = nxt_idx;
                        vld_d  = 1'b1;
                        we3_d  = instr_q.we3;
                        done_d = !more_after;
                    end
                end
            end
            FLUSH: begin
                // Empty mask: done pulse first, then one drain cycle before IDLE.
                done_d = 1'b0;
                if (!done_q)
                    state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                vld_d   = 1'b0;
                we3_d   = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            instr_q <= '0;
            mask_q  <= '0;
            bidx_q  <= '0;
            thr_q   <= '0;
            vld_q   <= 1'b0;
            we3_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            mask_q  <= mask_d;
            bidx_q  <= bidx_d;
            thr_q   <= thr_d;
            vld_q   <= vld_d;
            we3_q   <= we3_d;
            done_q  <= done_d;
        end
    end

    assign in_ready   = idle;
    assign busy       = !idle;
    assign lane_valid = vld_q;
    assign threads    = thr_q;
    assign bIdx       = bidx_q;
    assign FUNCT4     = instr_q.funct4;
    assign IMM        = instr_q.imm;
    assign AD1        = instr_q.ad1;
    assign AD2        = instr_q.ad2;
    assign AD3        = instr_q.ad3;
    assign is_int     = instr_q.is_int;
    assign is_float   = instr_q.is_float;
    assign WE3        = we3_q;
    assign done       = done_q;

endmodule

// File: tb/tb_lane_thread_issuer.sv
// Directed and randomized bench for lane_thread_issuer against a queue-based thread model.
module tb_lane_thread_issuer;
    import threading_pkg::*;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    in_valid = 1'b0;
    logic [3:0]              in_funct4 = '0;
    logic [31:0]             in_imm = '0;
    logic [4:0]              in_ad1 = '0, in_ad2 = '0, in_ad3 = '0;
    logic                    in_is_int = 1'b0, in_is_float = 1'b0, in_we3 = 1'b0;
    logic [NUM_THREADS-1:0]  in_mask = '0;
    logic [BIDX_W-1:0]       in_bidx = '0;
    logic                    stall = 1'b0;
    logic                    in_ready, lane_valid, is_int, is_float, WE3, busy, done;
    logic [THREAD_IDX_W-1:0] threads;
    logic [BIDX_W-1:0]       bIdx;
    logic [3:0]              FUNCT4;
    logic [31:0]             IMM;
    logic [4:0]              AD1, AD2, AD3;

    lane_thread_issuer dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_funct4(in_funct4), .in_imm(in_imm), .in_ad1(in_ad1), .in_ad2(in_ad2),
        .in_ad3(in_ad3), .in_is_int(in_is_int), .in_is_float(in_is_float),
        .in_we3(in_we3), .in_mask(in_mask), .in_bidx(in_bidx), .stall(stall),
        .lane_valid(lane_valid), .threads(threads), .bIdx(bIdx), .FUNCT4(FUNCT4),
        .IMM(IMM), .AD1(AD1), .AD2(AD2), .AD3(AD3), .is_int(is_int),
        .is_float(is_float), .WE3(WE3), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: 0 idle, 1 issuing, 2 flush with done, 3 flush drain.
    int          m_mode = 0;
    int          m_q[$];
    int          m_thr = 0;
    logic [31:0] m_bidx = '0, m_imm = '0;
    logic [3:0]  m_f4 = '0;
    logic [4:0]  m_a1 = '0, m_a2 = '0, m_a3 = '0;
    logic        m_isi = 1'b0, m_isf = 1'b0, m_we = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        if (!rst_n) begin
            m_mode = 0; m_q.delete(); m_thr = 0; m_bidx = '0; m_imm = '0; m_f4 = '0;
            m_a1 = '0; m_a2 = '0; m_a3 = '0; m_isi = 1'b0; m_isf = 1'b0; m_we = 1'b0;
        end else begin
            case (m_mode)
                0: if (in_valid) begin
                    m_f4 = in_funct4; m_imm = in_imm; m_a1 = in_ad1; m_a2 = in_ad2; m_a3 = in_ad3;
                    m_bidx = in_bidx;
                    m_isi = in_is_int;
                    m_isf = in_is_float && !in_is_int;
                    m_we = in_we3 && (in_is_int || in_is_float);
                    m_q.delete();
                    for (int i = 0; i < NUM_THREADS; i++)
                        if (in_mask[i]) m_q.push_back(i);
                    m_mode = (m_q.size() > 0) ? 1 : 2;
                end
                1: if (!stall) begin
                    void'(m_q.pop_front());
                    if (m_q.size() == 0) m_mode = 0;
                end
                2: m_mode = 3;
                default: m_mode = 0;
            endcase
            if (m_mode == 1) m_thr = m_q[0];
        end
    endtask

    task automatic check_outputs();
        logic issuing;
        issuing = (m_mode == 1);
        chk("in_ready", 64'(in_ready), 64'(m_mode == 0));
        chk("busy", 64'(busy), 64'(m_mode != 0));
        chk("lane_valid", 64'(lane_valid), 64'(issuing));
        chk("done", 64'(done), 64'((issuing && m_q.size() == 1) || m_mode == 2));
        chk("WE3", 64'(WE3), 64'(issuing && m_we));
        chk("threads", 64'(threads), 64'(m_thr));
        chk("bIdx", 64'(bIdx), 64'(m_bidx));
        chk("fields", {24'd0, FUNCT4, IMM, AD1, AD2, AD3, is_int, is_float},
            {24'd0, m_f4, m_imm, m_a1, m_a2, m_a3, m_isi, m_isf});
    endtask

    task automatic cycle(input logic st);
        stall = st;
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic load(input logic [15:0] m, input logic [31:0] b, input logic [3:0] f,
                        input logic [31:0] im, input logic [4:0] a1, input logic [4:0] a2,
                        input logic [4:0] a3, input logic ii, input logic fl, input logic we);
        in_valid = 1'b1; in_mask = m; in_bidx = b; in_funct4 = f; in_imm = im;
        in_ad1 = a1; in_ad2 = a2; in_ad3 = a3; in_is_int = ii; in_is_float = fl; in_we3 = we;
    endtask

    int exp_a005[4] = '{0, 2, 13, 15};
    int exp_stl[6]  = '{0, 1, 2, 2, 2, 3};
    logic stl_pat[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    int cnt_done, cnt_lowrdy, cnt_lv, n;

    initial begin
        // Reset state
        rst_n = 1'b0;
        cycle(1'b0);
        cycle(1'b1);
        chk("rst_ready", 64'(in_ready), 64'd1);
        chk("rst_done", 64'(done), 64'd0);
        rst_n = 1'b1;
        cycle(1'b1);

        // Single thread
        load(16'h0001, 32'h7, 4'd3, 32'hDEAD_BEEF, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b1);
        cycle(1'b0);
        in_valid = 1'b0;
        chk("t1_thr", 64'(threads), 64'd0);
        chk("t1_lv", 64'(lane_valid), 64'd1);
        chk("t1_we3", 64'(WE3), 64'd1);
        chk("t1_done", 64'(done), 64'd1);
        chk("t1_ad3", 64'(AD3), 64'd5);
        cycle(1'b0);
        chk("t1_ready", 64'(in_ready), 64'd1);

        // Sparse mask 0xA005
        load(16'hA005, 32'h12, 4'd9, 32'h1234, 5'd3, 5'd4, 5'd6, 1'b0, 1'b1, 1'b1);
        cycle(1'b0);
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("a005_thr", 64'(threads), 64'(exp_a005[k]));
            chk("a005_done", 64'(done), 64'(k == 3));
            chk("a005_bidx", 64'(bIdx), 64'h12);
            cycle(1'b0);
        end
        chk("a005_end_lv", 64'(lane_valid), 64'd0);

        // Stall while threads=2
        load(16'h000F, 32'h3, 4'd1, 32'h0, 5'd7, 5'd8, 5'd9, 1'b1, 1'b0, 1'b1);
        cnt_done = 0;
        for (int k = 0; k < 6; k++) begin
            cycle(stl_pat[k]);
            in_valid = 1'b0;
            chk("stall_thr", 64'(threads), 64'(exp_stl[k]));
            chk("stall_we3", 64'(WE3), 64'd1);
            cnt_done += int'(done);
        end
        cycle(1'b0);
        cnt_done += int'(done);
        chk("stall_done_cnt", 64'(cnt_done), 64'd1);

        // Empty mask
        load(16'h0000, 32'h55, 4'd2, 32'h9, 5'd1, 5'd1, 5'd1, 1'b1, 1'b0, 1'b1);
        cnt_done = 0; cnt_lowrdy = 0; cnt_lv = 0;
        for (int k = 0; k < 4; k++) begin
            cycle(1'b0);
            in_valid = 1'b0;
            if (k == 0) chk("flush_done_first", 64'(done), 64'd1);
            cnt_done += int'(done);
            cnt_lowrdy += int'(!in_ready);
            cnt_lv += int'(lane_valid);
        end
        chk("flush_done_cnt", 64'(cnt_done), 64'd1);
        chk("flush_rdy_low", 64'(cnt_lowrdy), 64'd2);
        chk("flush_lv", 64'(cnt_lv), 64'd0);

        // Unit-select sanitizing
        load(16'h0003, 32'h1, 4'd4, 32'h2, 5'd2, 5'd3, 5'd4, 1'b1, 1'b1, 1'b1);
        cycle(1'b0);
        in_valid = 1'b0;
        chk("both_isf", 64'(is_float), 64'd0);
        chk("both_isi", 64'(is_int), 64'd1);
        cycle(1'b0);
        cycle(1'b0);
        load(16'h0005, 32'h1, 4'd4, 32'h2, 5'd2, 5'd3, 5'd4, 1'b0, 1'b0, 1'b1);
        cnt_lv = 0;
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0);
            in_valid = 1'b0;
            chk("none_we3", 64'(WE3), 64'd0);
            cnt_lv += int'(lane_valid);
        end
        chk("none_lv_cnt", 64'(cnt_lv), 64'd2);

        // Reset mid-sequence
        load(16'hFFFF, 32'hAB, 4'd5, 32'h77, 5'd9, 5'd10, 5'd11, 1'b1, 1'b0, 1'b1);
        cycle(1'b0);
        in_valid = 1'b0;
        n = 0;
        while (threads != 4'd3 && n < 20) begin
            cycle(1'b0);
            n++;
        end
        chk("mid_reach3", 64'(threads), 64'd3);
        rst_n = 1'b0;
        cycle(1'b0);
        rst_n = 1'b1;
        chk("mid_rst_outs", {lane_valid, threads, bIdx, FUNCT4, IMM, AD1, AD2, AD3, is_int, is_float, WE3, busy, done},
            '0);
        chk("mid_rst_ready", 64'(in_ready), 64'd1);
        cycle(1'b0);
        chk("mid_no_done", 64'(done), 64'd0);
        load(16'hFFFF, 32'hAC, 4'd5, 32'h77, 5'd9, 5'd10, 5'd11, 1'b1, 1'b0, 1'b1);
        cycle(1'b0);
        in_valid = 1'b0;
        chk("restart_thr", 64'(threads), 64'd0);
        n = 0;
        while (busy && n < 40) begin
            cycle(1'b0);
            n++;
        end
        chk("restart_finish", 64'(busy), 64'd0);

        // Randomized traffic with stalls and occasional resets
        for (int c = 0; c < 600; c++) begin
            int kind;
            kind = $urandom_range(0, 3);
            in_valid    = ($urandom_range(0, 2) != 0);
            in_mask     = (kind == 0) ? 16'h0 : (kind == 1) ? (16'h1 << $urandom_range(0, 15)) : 16'($urandom);
            in_bidx     = $urandom;
            in_funct4   = 4'($urandom);
            in_imm      = $urandom;
            in_ad1      = 5'($urandom);
            in_ad2      = 5'($urandom);
            in_ad3      = 5'($urandom);
            in_is_int   = 1'($urandom);
            in_is_float = 1'($urandom);
            in_we3      = 1'($urandom);
            rst_n       = ($urandom_range(0, 63) != 0);
            cycle($urandom_range(0, 3) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lane_thread_issuer.md
Name: lane_thread_issuer

Overview:
- Stage directly upstream of the SIMT lane; consumes one decoded instruction per valid/ready handshake.
- Replays the instruction once per active thread in a thread mask, lowest index first, one thread per non-stalled cycle.
- Drives the lane's instruction fields: threads, bIdx, FUNCT4, IMM, AD1/AD2/AD3, is_int, is_float and WE3.
- Stall from the pipeline freezes the sequence in place.

Parameters:
- NUM_THREADS, 16, threads per lane; must be ≤ 2**THREAD_IDX_W.
- THREAD_IDX_W, 4, width of thread index.
- BIDX_W, 32, width of block index.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset; clock is clk, reset is rst_n, single clock domain
- in_valid  in  1  decoded instruction valid
- in_ready  out  1  issuer can accept an instruction
- in_funct4  in  4  ALU/FPU op
- in_imm  in  32  immediate
- in_ad1, in_ad2, in_ad3  in  5 each  read/read/write register addresses
- in_is_int, in_is_float  in  1 each  unit select
- in_we3  in  1  instruction writes a register
- in_mask  in  NUM_THREADS  active-thread mask
- in_bidx  in  BIDX_W  block index
- stall  in  1  downstream stall
- lane_valid  out  1  outputs carry a live thread issue
- threads  out  THREAD_IDX_W  current thread index
- bIdx  out  BIDX_W  latched block index
- FUNCT4, IMM, AD1, AD2, AD3  out  4/32/5/5/5  latched fields
- is_int, is_float  out  1 each  sanitized unit select
- WE3  out  1  lane register write enable
- busy  out  1  sequence in progress
- done  out  1  one-cycle completion pulse

Behaviour:
- States: IDLE, ISSUE, FLUSH.
- in_ready = (state==IDLE). Accept on rising edge with in_valid & in_ready. All fields latch into internal registers.
- Unit-select sanitizing at accept:
  - Both in_is_int and in_is_float set → is_int=1, is_float=0.
  - Neither set → WE3 forced 0 for the whole sequence.
  - Latched WE3 = in_we3 & (is_int | is_float).
- Accept with in_mask≠0 → state ISSUE.
  - threads = lowest set bit of mask; lane_valid=1 from the next cycle.
  - All outputs are registered.
- Accept with in_mask==0 → state FLUSH. Next cycle: done=1, lane_valid=0, then return to IDLE.
- ISSUE, stall=0:
  - Advance threads to the next set bit above the current index.
  - If no set bit remains: done=1 in the same cycle as the last issue, then IDLE next cycle (lane_valid=0, WE3=0).
- ISSUE, stall=1:
  - Every output, including WE3, lane_valid and done, is held unchanged.
  - No advance; the lane gates its own writes on stall.
  - A done held through stall is counted once.
- Latency: accept at edge N; k active threads with no stalls → issues on cycles N+1..N+k; in_ready=1 again at N+k+1.
- WE3 = latched we3 & lane_valid; never asserted outside ISSUE.
- busy = (state≠IDLE).
- IDLE outputs: lane_valid=0, WE3=0, done=0; data fields hold their last values.
- Reset (including mid-sequence): next cycle state=IDLE and every output is 0 (busy=0, done=0, in_ready=1). The aborted sequence never signals done.
- stall in IDLE has no effect; in_ready is not gated by stall.

Decomposition:
- Package threading_pkg:
  - NUM_THREADS, THREAD_IDX_W, BIDX_W.
  - issuer_state_t enum {IDLE, ISSUE, FLUSH}.
  - Packed struct lane_instr_t {funct4, imm, ad1, ad2, ad3, is_int, is_float, we3}, shared with the lane.
- Sub-module thread_mask_ffs: combinational next-set-bit finder. Inputs: mask and current index. Outputs: next index and a found flag. Also used for first-thread selection, with a "start" input that includes bit 0.

Test Plan:
- Mask 0x0001, funct4=3, ad3=5, we3=1, is_int=1 → one cycle with lane_valid=1, threads=0, WE3=1, done=1; in_ready=1 the following cycle.
- Mask 0xA005, we3=1, is_float=1 → threads 0,2,13,15 on four consecutive cycles; done only with 15; bIdx constant at the latched value (0x12).
- Mask 0x000F, stall=1 for 2 cycles while threads=2 → threads=2 held 3 cycles total with WE3=1; sequence 0,1,2,2,2,3; exactly one done pulse.
- Mask 0x0000 → lane_valid never 1; done=1 exactly one cycle after accept; in_ready low for 2 cycles total.
- Both is_int=1 and is_float=1 → is_float=0 on outputs. Neither set with we3=1 → WE3=0 on all issues while lane_valid still toggles per thread.
- Mask 0xFFFF with rst_n=0 during threads=3 → next cycle all outputs 0, in_ready=1, no done pulse; a new accept then starts from thread 0.
